// File: rtl/perf_pkg.sv
// Shared constants and types for the performance-counter arbiter.
//
// Contents:
//   PERF_NUM_REQ / PERF_NUM_CNT / PERF_CNT_W : default configuration
//   rsp_t                                    : response record {data, ovf, err}
//                                              at the default counter width
//   idxWidth()                               : counter-index width, never below 1
package perf_pkg;

    localparam int PERF_NUM_REQ = 4;
    localparam int PERF_NUM_CNT = 8;
    localparam int PERF_CNT_W   = 16;

    typedef struct packed {
        logic [PERF_CNT_W-1:0] data;
        logic                  ovf;
        logic                  err;
    } rsp_t;

    // A single counter still needs a one-bit index so port widths stay legal.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   req[N]   : request vector
//   gnt[N]   : one-hot grant, combinational; forced to zero while in reset
//   ptr      : current priority pointer (the requester searched first)
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_winner;
    logic          w_found;
    int            w_cand;

    // Walk the requesters starting at the pointer, wrapping modulo N;
    // the first asserted request wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = 0;
        gnt      = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = (int'(r_ptr) + i) % N;
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = PW'(w_cand);
            end
        end
        if (w_found && reset_n) begin
            gnt[w_winner] = 1'b1;
        end
    end

    // The pointer only moves past the winner when a grant is issued;
    // idle cycles leave the priority order untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (int'(w_winner) == N - 1) ? '0 : w_winner + 1'b1;
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/perf_cnt_arbiter.sv
// Bank of event counters shared between several software requesters.
// One read (peek or read-and-clear) is granted per cycle by a round-robin
// arbiter; the response appears one cycle after the grant.
//
// Ports:
//   clk, reset_n   : clock (rising edge), asynchronous active-low reset
//   evt_i          : per-counter event pulse
//   freeze_i       : ignore all events while high
//   req_i          : per-requester read request
//   req_idx_i      : packed counter indices, requester r at [r*IDX_W +: IDX_W]
//   req_clr_i      : 1 = read-and-clear, 0 = peek
//   gnt_o          : one-hot grant (combinational)
//   rsp_valid_o    : one-hot response strobe, one cycle after the grant
//   rsp_data_o     : counter value sampled in the grant cycle
//   rsp_ovf_o      : sticky overflow flag of that counter
//   rsp_err_o      : requested index was out of range
module perf_cnt_arbiter
    import perf_pkg::*;
#(
    parameter  int NUM_REQ = PERF_NUM_REQ,
    parameter  int NUM_CNT = PERF_NUM_CNT,
    parameter  int CNT_W   = PERF_CNT_W,
    localparam int IDX_W   = idxWidth(NUM_CNT)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CNT-1:0]       evt_i,
    input  logic                     freeze_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx_i,
    input  logic [NUM_REQ-1:0]       req_clr_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    output logic [CNT_W-1:0]         rsp_data_o,
    output logic                     rsp_ovf_o,
    output logic                     rsp_err_o
);

    logic [CNT_W-1:0]   r_cnt [NUM_CNT];
    logic [NUM_CNT-1:0] r_ovf;

    logic [NUM_REQ-1:0] r_rspValid;
    logic [CNT_W-1:0]   r_rspData;
    logic               r_rspOvf;
    logic               r_rspErr;

    logic [NUM_REQ-1:0] w_gnt;
    logic               w_anyGnt;
    logic [IDX_W-1:0]   w_idx;
    logic               w_clr;
    logic               w_idxErr;
    logic [CNT_W-1:0]   w_rdData;
    logic               w_rdOvf;
    logic [NUM_CNT-1:0] w_inc;
    logic [NUM_CNT-1:0] w_clrHit;
    logic [NUM_CNT-1:0] w_wrap;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_i),
        .gnt     (w_gnt),
        .ptr     ()
    );

    // Select the winning requester's index and clear bit, then fetch the
    // counter it names. Out-of-range indices read back as zero.
    always_comb begin
        w_idx    = '0;
        w_clr    = 1'b0;
        w_rdData = '0;
        w_rdOvf  = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_gnt[r]) begin
                w_idx = req_idx_i[r*IDX_W +: IDX_W];
                w_clr = req_clr_i[r];
            end
        end
        w_anyGnt = |w_gnt;
        w_idxErr = (int'(w_idx) >= NUM_CNT);
        for (int k = 0; k < NUM_CNT; k++) begin
            if (!w_idxErr && int'(w_idx) == k) begin
                w_rdData = r_cnt[k];
                w_rdOvf  = r_ovf[k];
            end
        end
    end

    // Per-counter control: an event counts unless frozen; a granted clear
    // hits only a valid index; a wrap is an event on an all-ones counter.
    always_comb begin
        w_inc    = '0;
        w_clrHit = '0;
        w_wrap   = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            w_inc[k]    = evt_i[k] & ~freeze_i;
            w_clrHit[k] = w_anyGnt & w_clr & ~w_idxErr & (int'(w_idx) == k);
            w_wrap[k]   = w_inc[k] & (r_cnt[k] == '1);
        end
    end

    // Counter bank. A clear colliding with an event leaves the counter at 1,
    // so the event is not lost; the overflow flag survives a clear only when
    // that same event wraps the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                r_cnt[k] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int k = 0; k < NUM_CNT; k++) begin
                if (w_clrHit[k]) begin
                    r_cnt[k] <= w_inc[k] ? CNT_W'(1) : '0;
                    r_ovf[k] <= w_wrap[k];
                end else if (w_inc[k]) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                    if (w_wrap[k]) begin
                        r_ovf[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // Response register: the strobe follows the grant by one cycle, while
    // the payload only updates on a grant and otherwise holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rspValid <= '0;
            r_rspData  <= '0;
            r_rspOvf   <= 1'b0;
            r_rspErr   <= 1'b0;
        end else begin
            r_rspValid <= w_gnt;
            if (w_anyGnt) begin
                r_rspData <= w_rdData;
                r_rspOvf  <= w_rdOvf;
                r_rspErr  <= w_idxErr;
            end
        end
    end

    assign gnt_o       = w_gnt;
    assign rsp_valid_o = r_rspValid;
    assign rsp_data_o  = r_rspData;
    assign rsp_ovf_o   = r_rspOvf;
    assign rsp_err_o   = r_rspErr;

endmodule

// File: tb/tb_perf_cnt_arbiter.sv
// Testbench for perf_cnt_arbiter.
// Two instances share the clock and reset: the default configuration
// (4 requesters, 8 counters, 16-bit) and a small one (6 counters, 4-bit)
// for wrap-around and out-of-range index cases.
module tb_perf_cnt_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [7:0]  evt;
    logic        frz;
    logic [3:0]  req;
    logic [11:0] reqIdx;
    logic [3:0]  reqClr;
    logic [3:0]  gnt;
    logic [3:0]  vld;
    logic [15:0] data;
    logic        ovf;
    logic        err;

    logic [5:0]  sEvt;
    logic        sFrz;
    logic [3:0]  sReq;
    logic [11:0] sIdx;
    logic [3:0]  sClr;
    logic [3:0]  sGnt;
    logic [3:0]  sVld;
    logic [3:0]  sData;
    logic        sOvf;
    logic        sErr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  req;
        logic [2:0]  idx;
        logic [3:0]  clr;
        logic [7:0]  evt;
        logic        frz;
        logic [3:0]  expGnt;
        logic [3:0]  expVld;
        logic        chkData;
        logic [15:0] expData;
        logic        expOvf;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];

    perf_cnt_arbiter u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .evt_i       (evt),
        .freeze_i    (frz),
        .req_i       (req),
        .req_idx_i   (reqIdx),
        .req_clr_i   (reqClr),
        .gnt_o       (gnt),
        .rsp_valid_o (vld),
        .rsp_data_o  (data),
        .rsp_ovf_o   (ovf),
        .rsp_err_o   (err)
    );

    perf_cnt_arbiter #(
        .NUM_REQ (4),
        .NUM_CNT (6),
        .CNT_W   (4)
    ) u_small (
        .clk         (clk),
        .reset_n     (reset_n),
        .evt_i       (sEvt),
        .freeze_i    (sFrz),
        .req_i       (sReq),
        .req_idx_i   (sIdx),
        .req_clr_i   (sClr),
        .gnt_o       (sGnt),
        .rsp_valid_o (sVld),
        .rsp_data_o  (sData),
        .rsp_ovf_o   (sOvf),
        .rsp_err_o   (sErr)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input logic [3:0] r, input logic [2:0] i,
                                input logic [3:0] c, input logic [7:0] e,
                                input logic f, input logic [3:0] g,
                                input logic [3:0] v, input logic chk,
                                input logic [15:0] d);
        vec_t t;
        t.req     = r;
        t.idx     = i;
        t.clr     = c;
        t.evt     = e;
        t.frz     = f;
        t.expGnt  = g;
        t.expVld  = v;
        t.chkData = chk;
        t.expData = d;
        t.expOvf  = 1'b0;
        t.expErr  = 1'b0;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req    = v.req;
        reqIdx = {4{v.idx}};
        reqClr = v.clr;
        evt    = v.evt;
        frz    = v.frz;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smallDrive(input logic [3:0] r, input logic [2:0] i,
                              input logic [3:0] c, input logic [5:0] e);
        sReq = r;
        sIdx = {4{i}};
        sClr = c;
        sEvt = e;
    endtask

    task automatic smallRsp(input string name, input logic [3:0] v,
                            input logic [3:0] d, input logic o, input logic e);
        checkOutput({name, " vld"}, 32'(sVld), 32'(v));
        checkOutput({name, " data"}, 32'(sData), 32'(d));
        checkOutput({name, " ovf"}, 32'(sOvf), 32'(o));
        checkOutput({name, " err"}, 32'(sErr), 32'(e));
    endtask

    initial begin
        // Table: {req, idx, clr, evt, frz, expGnt, expVld, chkData, expData}
        // Five events on counter 2, then two peeks of it.
        for (int i = 0; i < 5; i++) vecs.push_back(mk(4'b0000, 3'd2, 4'b0000, 8'h04, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd0));
        vecs.push_back(mk(4'b0001, 3'd2, 4'b0000, 8'h00, 1'b0, 4'b0001, 4'b0000, 1'b0, 16'd0));
        vecs.push_back(mk(4'b0001, 3'd2, 4'b0000, 8'h00, 1'b0, 4'b0001, 4'b0001, 1'b1, 16'd5));
        // Requester 3 alone brings the pointer back to 0.
        vecs.push_back(mk(4'b1000, 3'd2, 4'b0000, 8'h00, 1'b0, 4'b1000, 4'b0001, 1'b1, 16'd5));
        // All four hold their requests: grants 0,1,2,3,0.
        vecs.push_back(mk(4'b1111, 3'd2, 4'b0000, 8'h00, 1'b0, 4'b0001, 4'b1000, 1'b1, 16'd5));
        vecs.push_back(mk(4'b1111, 3'd2, 4'b0000, 8'h00, 1'b0, 4'b0010, 4'b0001, 1'b1, 16'd5));
        vecs.push_back(mk(4'b1111, 3'd2, 4'b0000, 8'h00, 1'b0, 4'b0100, 4'b0010, 1'b1, 16'd5));
        vecs.push_back(mk(4'b1111, 3'd2, 4'b0000, 8'h00, 1'b0, 4'b1000, 4'b0100, 1'b1, 16'd5));
        vecs.push_back(mk(4'b1111, 3'd2, 4'b0000, 8'h00, 1'b0, 4'b0001, 4'b1000, 1'b1, 16'd5));
        vecs.push_back(mk(4'b0000, 3'd2, 4'b0000, 8'h00, 1'b0, 4'b0000, 4'b0001, 1'b1, 16'd5));
        vecs.push_back(mk(4'b0000, 3'd2, 4'b0000, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b1, 16'd5));
        // Three events on counter 1 while frozen, two after: peek gives 2.
        for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b0000, 3'd1, 4'b0000, 8'h02, 1'b1, 4'b0000, 4'b0000, 1'b0, 16'd0));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(4'b0000, 3'd1, 4'b0000, 8'h02, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd0));
        vecs.push_back(mk(4'b0100, 3'd1, 4'b0000, 8'h00, 1'b0, 4'b0100, 4'b0000, 1'b0, 16'd0));
        vecs.push_back(mk(4'b0000, 3'd1, 4'b0000, 8'h00, 1'b0, 4'b0000, 4'b0100, 1'b1, 16'd2));
        // Counter 3 to 7, then read-and-clear with a colliding event.
        for (int i = 0; i < 7; i++) vecs.push_back(mk(4'b0000, 3'd3, 4'b0000, 8'h08, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd0));
        vecs.push_back(mk(4'b0010, 3'd3, 4'b0010, 8'h08, 1'b0, 4'b0010, 4'b0000, 1'b0, 16'd0));
        vecs.push_back(mk(4'b0000, 3'd3, 4'b0000, 8'h00, 1'b0, 4'b0000, 4'b0010, 1'b1, 16'd7));
        vecs.push_back(mk(4'b0010, 3'd3, 4'b0000, 8'h00, 1'b0, 4'b0010, 4'b0000, 1'b0, 16'd0));
        vecs.push_back(mk(4'b0000, 3'd3, 4'b0000, 8'h00, 1'b0, 4'b0000, 4'b0010, 1'b1, 16'd1));

        // Reset with requests pending: no grants, everything cleared.
        reset_n = 1'b0;
        req = 4'b1111; reqIdx = '0; reqClr = '0; evt = '0; frz = 1'b0;
        sReq = '0; sIdx = '0; sClr = '0; sEvt = '0; sFrz = 1'b0;
        #1;
        checkOutput("reset gnt", 32'(gnt), 32'h0);
        tick();
        tick();
        checkOutput("reset vld", 32'(vld), 32'h0);
        checkOutput("reset data", 32'(data), 32'h0);
        checkOutput("reset ovf", 32'(ovf), 32'h0);
        checkOutput("reset err", 32'(err), 32'h0);
        checkOutput("reset gnt held", 32'(gnt), 32'h0);
        checkOutput("reset small vld", 32'(sVld), 32'h0);
        reset_n = 1'b1;
        req = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            tick();
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d gnt", i), 32'(gnt), 32'(vecs[i].expGnt));
            checkOutput($sformatf("row%0d vld", i), 32'(vld), 32'(vecs[i].expVld));
            if (vecs[i].chkData) begin
                checkOutput($sformatf("row%0d data", i), 32'(data), 32'(vecs[i].expData));
                checkOutput($sformatf("row%0d ovf", i), 32'(ovf), 32'(vecs[i].expOvf));
                checkOutput($sformatf("row%0d err", i), 32'(err), 32'(vecs[i].expErr));
            end
        end

        // Reset asserted right after a grant: its response never appears.
        tick();
        req = 4'b0001; reqIdx = {4{3'd3}}; reqClr = '0; evt = '0;
        #1;
        checkOutput("mid grant", 32'(gnt), 32'b0001);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("mid gnt in reset", 32'(gnt), 32'h0);
        tick();
        checkOutput("mid vld in reset", 32'(vld), 32'h0);
        req = '0;
        tick();
        checkOutput("mid vld in reset 2", 32'(vld), 32'h0);
        tick();
        reset_n = 1'b1;
        req = 4'b1111; reqIdx = {4{3'd3}};
        #1;
        checkOutput("post reset ptr", 32'(gnt), 32'b0001);
        tick();
        req = 4'b0010; reqIdx = {4{3'd2}};
        #1;
        checkOutput("post reset vld", 32'(vld), 32'b0001);
        checkOutput("post reset cnt3", 32'(data), 32'h0);
        checkOutput("post reset gnt1", 32'(gnt), 32'b0010);
        tick();
        req = '0;
        #1;
        checkOutput("post reset cnt2", 32'(data), 32'h0);
        checkOutput("post reset vld2", 32'(vld), 32'b0010);

        // Small config: 17 events on a 4-bit counter wrap it to 1 with overflow.
        for (int i = 0; i < 17; i++) begin
            tick();
            smallDrive(4'b0000, 3'd0, 4'b0000, 6'b000001);
        end
        tick();
        smallDrive(4'b0001, 3'd0, 4'b0000, 6'b000000);
        #1;
        checkOutput("wrap peek gnt", 32'(sGnt), 32'b0001);
        tick();
        smallDrive(4'b0001, 3'd0, 4'b0001, 6'b000000);
        #1;
        smallRsp("wrap peek", 4'b0001, 4'd1, 1'b1, 1'b0);
        checkOutput("wrap clr gnt", 32'(sGnt), 32'b0001);
        tick();
        smallDrive(4'b0001, 3'd0, 4'b0000, 6'b000000);
        #1;
        smallRsp("wrap clr", 4'b0001, 4'd1, 1'b1, 1'b0);
        tick();
        smallDrive(4'b0000, 3'd0, 4'b0000, 6'b000000);
        #1;
        smallRsp("after clr", 4'b0001, 4'd0, 1'b0, 1'b0);

        // Out-of-range index 7 with clear requested: error, nothing modified.
        for (int i = 0; i < 3; i++) begin
            tick();
            smallDrive(4'b0000, 3'd0, 4'b0000, 6'b100000);
        end
        tick();
        smallDrive(4'b0001, 3'd7, 4'b0001, 6'b000000);
        #1;
        checkOutput("bad idx gnt", 32'(sGnt), 32'b0001);
        tick();
        smallDrive(4'b0001, 3'd5, 4'b0000, 6'b000000);
        #1;
        smallRsp("bad idx", 4'b0001, 4'd0, 1'b0, 1'b1);
        tick();
        smallDrive(4'b0001, 3'd0, 4'b0000, 6'b000000);
        #1;
        smallRsp("cnt5 kept", 4'b0001, 4'd3, 1'b0, 1'b0);
        tick();
        smallDrive(4'b0000, 3'd0, 4'b0000, 6'b000000);
        #1;
        smallRsp("cnt0 kept", 4'b0001, 4'd0, 1'b0, 1'b0);
        tick();
        #1;
        smallRsp("idle hold", 4'b0000, 4'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
